digest_tx_scheduler: RTL and testbench

Shares one ASCII byte-stream output (UART TX path) between two SHA-256 hash cores. Round-robin arbitration picks a requesting core, latches its 256-bit digest, and streams it as 64 lowercase ASCII hex characters, MSB nibble first, with an optional CR/LF terminator. Uses a valid/ready handshake downstream and a one-cycle grant pulse upstream.

---
 rtl/digest_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_digest_tx_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/digest_tx_scheduler.sv
// Round-robin arbiter between two SHA-256 cores that streams the granted 256-bit digest
// as 64 lowercase ASCII hex characters (MSB nibble first), optionally followed by CR/LF.
module digest_tx_scheduler #(
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic [255:0] Digest0,
    input  logic         Req1,
    input  logic [255:0] Digest1,
    output logic         Grant0,
    output logic         Grant1,
    output logic [7:0]   TxData,
    output logic         TxValid,
    input  logic         TxReady,
    output logic         Busy,
    output logic         Done,
    output logic         Src
);

    typedef enum logic [1:0] {StIdle, StSendHex, StSendCr, StSendLf} state_e;

    state_e        state_q, state_d;
    logic [255:0]  digest_q, digest_d;
    logic [5:0]    idx_q, idx_d;
    logic          src_q, src_d;
    logic          last_q, last_d;
    logic          grant0_q, grant0_d;
    logic          grant1_q, grant1_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          xfer;
    logic          pick1;
    logic          finish;
    logic [255:0]  win;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        to_ascii = (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
    endfunction

    assign xfer = tx_valid_q & TxReady;

    always_comb begin
        state_d    = state_q;
        digest_d   = digest_q;
        idx_d      = idx_q;
        src_d      = src_q;
        last_d     = last_q;
        grant0_d   = 1'b0;
        grant1_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        finish     = 1'b0;
        // last_q holds the core served last; on a tie the other core wins.
        pick1      = Req1 & (~Req0 | ~last_q);
        win        = pick1 ? Digest1 : Digest0;

        unique case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    src_d      = pick1;
                    digest_d   = win;
                    grant0_d   = ~pick1;
                    grant1_d   = pick1;
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = to_ascii(win[255:252]);
                    idx_d      = 6'd0;
                    state_d    = StSendHex;
                end
            end
            StSendHex: begin
                if (xfer) begin
                    if (idx_q == 6'd63) begin
                        if (APPEND_CRLF) begin
                            tx_data_d = 8'h0D;
                            state_d   = StSendCr;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        // Digest register shifts so the next nibble is always at [251:248].
                        idx_d     = idx_q + 6'd1;
                        digest_d  = {digest_q[251:0], 4'h0};
                        tx_data_d = to_ascii(digest_q[251:248]);
                    end
                end
            end
            StSendCr: begin
                if (xfer) begin
                    tx_data_d = 8'h0A;
                    state_d   = StSendLf;
                end
            end
            StSendLf: begin
                if (xfer) begin
                    finish = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            last_d     = src_q;
            state_d    = StIdle;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            digest_q   <= '0;
            idx_q      <= '0;
            src_q      <= 1'b0;
            last_q     <= 1'b1;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digest_q   <= digest_d;
            idx_q      <= idx_d;
            src_q      <= src_d;
            last_q     <= last_d;
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Grant0  = grant0_q;
    assign Grant1  = grant1_q;
    assign TxData  = tx_data_q;
    assign TxValid = tx_valid_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Src     = src_q;

endmodule

// File: tb/tb_digest_tx_scheduler.sv
// Directed bench for digest_tx_scheduler: one instance with CR/LF, one without.
module tb_digest_tx_scheduler;

    logic         Clk;
    logic         Reset;
    logic         Req0, Req1, TxReady;
    logic [255:0] Digest0, Digest1;
    logic         Grant0, Grant1, TxValid, Busy, Done, Src;
    logic [7:0]   TxData;

    logic         b_req0, b_req1, b_ready;
    logic [255:0] b_dig0, b_dig1;
    logic         b_grant0, b_grant1, b_valid, b_busy, b_done, b_src;
    logic [7:0]   b_data;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] D0 = {4{64'h0123456789abcdef}};
    localparam logic [255:0] D1 = {64'hfedcba9876543210, 64'hdeadbeefcafef00d,
                                   64'h0f1e2d3c4b5a6978, 64'h8899aabbccddeeff};
    localparam logic [255:0] DA = {4{64'h13579bdf02468ace}};
    localparam logic [255:0] DB = {4{64'hffffffff00000000}};

    digest_tx_scheduler #(.APPEND_CRLF(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Digest0(Digest0), .Req1(Req1), .Digest1(Digest1),
        .Grant0(Grant0), .Grant1(Grant1),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .Busy(Busy), .Done(Done), .Src(Src)
    );

    digest_tx_scheduler #(.APPEND_CRLF(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .Req0(b_req0), .Digest0(b_dig0), .Req1(b_req1), .Digest1(b_dig1),
        .Grant0(b_grant0), .Grant1(b_grant1),
        .TxData(b_data), .TxValid(b_valid), .TxReady(b_ready),
        .Busy(b_busy), .Done(b_done), .Src(b_src)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [255:0] d, input int i);
        string hx;
        hx = "0123456789abcdef";
        if (i < 64) return hx[int'(d[255-4*i -: 4])];
        return (i == 64) ? 8'h0D : 8'h0A;
    endfunction

    // Call right after the grant edge with TxReady=1: expects 66 back-to-back bytes then Done.
    task automatic stream_a(input logic [255:0] d);
        for (int i = 0; i < 66; i++) begin
            chk8("byte", TxData, exp_byte(d, i));
            chk1("valid", TxValid, 1'b1);
            if (i == 1) chk1("grant_drop", Grant0 | Grant1, 1'b0);
            if (i == 30) chk1("busy_mid", Busy, 1'b1);
            step();
        end
        chk1("done", Done, 1'b1);
        chk1("busy_at_done", Busy, 1'b0);
        chk1("valid_at_done", TxValid, 1'b0);
    endtask

    initial begin
        int   n;
        int   cyc;
        logic v;
        logic [7:0] dat;
        bit   r;

        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; TxReady = 1'b1;
        Digest0 = D0; Digest1 = D1;
        b_req0 = 1'b0; b_req1 = 1'b0; b_ready = 1'b1; b_dig0 = '1; b_dig1 = '0;
        #2 Reset = 1'b0;
        #1;
        chk1("rst_valid", TxValid, 1'b0);
        chk8("rst_data", TxData, 8'h00);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        chk1("rst_grant", Grant0 | Grant1, 1'b0);
        chk1("rst_src", Src, 1'b0);
        step();
        step();
        Reset = 1'b1;

        // Single request, TxReady tied high
        Req0 = 1'b1;
        step();
        chk1("t1_grant0", Grant0, 1'b1);
        chk1("t1_grant1", Grant1, 1'b0);
        chk1("t1_busy", Busy, 1'b1);
        chk1("t1_src", Src, 1'b0);
        Req0 = 1'b0;
        stream_a(D0);

        // Backpressure on core 1
        Req1 = 1'b1;
        step();
        chk1("t2_grant1", Grant1, 1'b1);
        chk1("t2_src", Src, 1'b1);
        Req1 = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 66 && cyc < 1000) begin
            r = 1'($urandom_range(0, 1));
            TxReady = r;
            v = TxValid;
            dat = TxData;
            if (v && r) begin
                chk8("bp_byte", dat, exp_byte(D1, n));
                n++;
            end
            step();
            if (v && !r) begin
                chk8("bp_hold_data", TxData, dat);
                chk1("bp_hold_valid", TxValid, 1'b1);
            end
            cyc++;
        end
        chk1("bp_all_bytes", n == 66, 1'b1);
        chk1("bp_done", Done, 1'b1);
        TxReady = 1'b1;

        // Contention from reset: order 0,1,0,1, each grant one cycle after Done
        Reset = 1'b0;
        step();
        Req0 = 1'b1;
        Req1 = 1'b1;
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("rr_grant0", Grant0, (k % 2) == 0);
            chk1("rr_grant1", Grant1, (k % 2) == 1);
            chk1("rr_src", Src, (k % 2) == 1);
            stream_a(((k % 2) == 1) ? D1 : D0);
        end
        Req0 = 1'b0;
        Req1 = 1'b0;

        // Requests and digest changes during a stream are ignored
        Digest0 = DA;
        Req0 = 1'b1;
        step();
        chk1("ign_grant0", Grant0, 1'b1);
        Req0 = 1'b0;
        Req1 = 1'b1;
        Digest0 = DB;
        stream_a(DA);
        step();
        chk1("ign_grant1", Grant1, 1'b1);
        chk1("ign_src", Src, 1'b1);
        Req1 = 1'b0;
        stream_a(D1);

        // Serve core 0 fully so the pointer would favour core 1 without a reset
        Digest0 = D0;
        Req0 = 1'b1;
        step();
        chk1("pre_grant0", Grant0, 1'b1);
        Req0 = 1'b0;
        stream_a(D0);

        // Reset mid-stream of core 1
        Req1 = 1'b1;
        step();
        chk1("mr_grant1", Grant1, 1'b1);
        Req1 = 1'b0;
        for (int i = 0; i < 21; i++) step();
        chk1("mr_busy_before", Busy, 1'b1);
        chk1("mr_src_before", Src, 1'b1);
        Reset = 1'b0;
        #1;
        chk1("mr_valid", TxValid, 1'b0);
        chk8("mr_data", TxData, 8'h00);
        chk1("mr_busy", Busy, 1'b0);
        chk1("mr_done", Done, 1'b0);
        chk1("mr_src", Src, 1'b0);
        Req0 = 1'b1;
        Req1 = 1'b1;
        step();
        Reset = 1'b1;
        step();
        chk1("mr_post_grant0", Grant0, 1'b1);
        chk1("mr_post_grant1", Grant1, 1'b0);
        chk1("mr_post_done", Done, 1'b0);
        Req0 = 1'b0;
        Req1 = 1'b0;
        stream_a(D0);

        // No CR/LF instance, all-F digest
        b_req0 = 1'b1;
        step();
        chk1("nc_grant0", b_grant0, 1'b1);
        b_req0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk8("nc_byte", b_data, 8'h66);
            chk1("nc_valid", b_valid, 1'b1);
            step();
        end
        chk1("nc_done", b_done, 1'b1);
        chk1("nc_valid_end", b_valid, 1'b0);
        chk1("nc_busy_end", b_busy, 1'b0);
        step();
        chk1("nc_no_crlf", b_valid, 1'b0);
        chk1("nc_done_pulse", b_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
